// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared types for the decode-stage hazard logic.
//   REG_ADDR_W  - architectural register address width
//   TRACK_DEPTH - downstream stages tracked by the scoreboard (EX, MEM, WB)
//   fwd_sel_t   - EX operand source select encoding
//   sb_entry_t  - one in-flight register writer {valid, dst, is_load}
//   src_hit()   - does a decode source read the register an entry writes?
package pipeline_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int TRACK_DEPTH = 3;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst;
        logic                  is_load;
    } sb_entry_t;

    // Register 0 is hardwired, so a read of it never depends on a writer.
    function automatic logic src_hit(input logic                  used,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input sb_entry_t             e);
        return used && e.valid && (src == e.dst) && (src != '0);
    endfunction

endpackage

// File: rtl/hazard_detect_unit_if.sv
// hazard_detect_unit_if
// Decode-slot bundle between the decode stage and the hazard unit.
//   master : decode side, drives the id_* fields and flush
//   slave  : hazard unit, returns the stall predicate, forwarding selects
//            and the scoreboard contents (dbg_ex/dbg_mem/dbg_wb)
// There is no valid/ready handshake: id_valid only marks that the decode
// slot holds a real instruction; load_write_predicate tells the stall
// engine to hold that instruction in decode for this cycle.
interface hazard_detect_unit_if;
    import pipeline_pkg::*;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic [REG_ADDR_W-1:0] id_dst;
    logic                  id_reg_write;
    logic                  id_is_load;
    logic                  flush;
    logic                  load_write_predicate;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    sb_entry_t             dbg_ex;
    sb_entry_t             dbg_mem;
    sb_entry_t             dbg_wb;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_dst, id_reg_write, id_is_load, flush,
        input  load_write_predicate, fwd_a_sel, fwd_b_sel,
               dbg_ex, dbg_mem, dbg_wb
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_dst, id_reg_write, id_is_load, flush,
        output load_write_predicate, fwd_a_sel, fwd_b_sel,
               dbg_ex, dbg_mem, dbg_wb
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Shift register of in-flight register writers: stage 0 = EX, 1 = MEM,
// 2 = WB. A decode instruction enters EX only when it issues, writes a
// register and that register is not $0; otherwise a bubble enters.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (clears all entries)
//   issue         - decode instruction advances into EX this cycle
//   reg_write     - it writes dst
//   dst           - destination register
//   is_load       - it is a load
//   ex, mem, wb   - current entry contents
module hazard_scoreboard
    import pipeline_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] dst,
    input  logic                  is_load,
    output sb_entry_t             ex,
    output sb_entry_t             mem,
    output sb_entry_t             wb
);

    sb_entry_t stage_q [TRACK_DEPTH];
    sb_entry_t incoming;

    always_comb begin
        incoming = '0;
        if (issue && reg_write && (dst != '0)) begin
            incoming.valid   = 1'b1;
            incoming.dst     = dst;
            incoming.is_load = is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TRACK_DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= incoming;
            for (int i = 1; i < TRACK_DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign ex  = stage_q[0];
    assign mem = stage_q[1];
    assign wb  = stage_q[2];

endmodule

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit
// Decode-stage hazard unit: raises load_write_predicate (stall request)
// for the decode instruction and produces EX-aligned forwarding selects.
// Ports:
//   clk, rst - pipeline clock, synchronous active-high reset
//   bus      - hazard_detect_unit_if.slave (decode fields in, stall,
//              fwd_a_sel/fwd_b_sel and scoreboard contents out)
// Build option HAZARD_FWD_EN:
//   defined   - EX/MEM and MEM/WB forwarding; only a load in EX stalls
//   undefined - no forwarding (selects stay 0); any writer in EX or MEM
//               that a source reads stalls. WB is always covered by the
//               write-first register file.
module hazard_detect_unit
    import pipeline_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    hazard_detect_unit_if.slave  bus
);

    sb_entry_t ex_entry, mem_entry, wb_entry;
    logic      issue;
    logic      stall_cond;
    logic      predicate;
    logic      hit_rs_ex, hit_rt_ex, hit_rs_mem, hit_rt_mem;

    assign hit_rs_ex  = src_hit(bus.id_rs_used, bus.id_rs, ex_entry);
    assign hit_rt_ex  = src_hit(bus.id_rt_used, bus.id_rt, ex_entry);
    assign hit_rs_mem = src_hit(bus.id_rs_used, bus.id_rs, mem_entry);
    assign hit_rt_mem = src_hit(bus.id_rt_used, bus.id_rt, mem_entry);

`ifdef HAZARD_FWD_EN
    // A load result is not available until after MEM, so only a load in
    // EX has to hold the consumer; everything else is forwarded.
    assign stall_cond = ex_entry.is_load & (hit_rs_ex | hit_rt_ex);
`else
    assign stall_cond = hit_rs_ex | hit_rt_ex | hit_rs_mem | hit_rt_mem;
`endif

    // Flush wins over a stall: the killed instruction becomes a bubble.
    assign predicate = ~rst & bus.id_valid & ~bus.flush & stall_cond;
    assign issue     = bus.id_valid & ~bus.flush & ~predicate;

    assign bus.load_write_predicate = predicate;

    hazard_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .reg_write (bus.id_reg_write),
        .dst       (bus.id_dst),
        .is_load   (bus.id_is_load),
        .ex        (ex_entry),
        .mem       (mem_entry),
        .wb        (wb_entry)
    );

    assign bus.dbg_ex  = ex_entry;
    assign bus.dbg_mem = mem_entry;
    assign bus.dbg_wb  = wb_entry;

`ifdef HAZARD_FWD_EN
    fwd_sel_t fwd_a_q, fwd_b_q;

    // The youngest writer (EX) wins over MEM.
    function automatic fwd_sel_t fwd_pick(input logic hit_ex,
                                          input logic hit_mem,
                                          input logic ex_is_load);
        if (hit_ex && !ex_is_load) return FWD_EXMEM;
        else if (hit_mem)          return FWD_MEMWB;
        else                       return FWD_RF;
    endfunction

    // Registered so the select lines up with the instruction in EX;
    // a bubble entering EX carries select 0.
    always_ff @(posedge clk) begin
        if (rst || !issue) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_pick(hit_rs_ex, hit_rs_mem, ex_entry.is_load);
            fwd_b_q <= fwd_pick(hit_rt_ex, hit_rt_mem, ex_entry.is_load);
        end
    end

    assign bus.fwd_a_sel = fwd_a_q;
    assign bus.fwd_b_sel = fwd_b_q;
`else
    assign bus.fwd_a_sel = FWD_RF;
    assign bus.fwd_b_sel = FWD_RF;
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb_hazard_detect_unit
// Bench for hazard_detect_unit. Expected selects are pushed with each
// driven decode slot and popped after the following clock edge; the
// combinational stall predicate is checked mid-cycle.
module tb_hazard_detect_unit;
    import pipeline_pkg::*;

`ifdef HAZARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [3:0] exp_q[$];   // {fwd_a_sel, fwd_b_sel} expected after the edge

    hazard_detect_unit_if bus ();

    hazard_detect_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic apply(input logic v,
                         input logic [4:0] rs, input logic rs_used,
                         input logic [4:0] rt, input logic rt_used,
                         input logic [4:0] dst, input logic rw,
                         input logic ld, input logic fl,
                         input logic [3:0] exp_fwd);
        bus.id_valid     = v;
        bus.id_rs        = rs;
        bus.id_rs_used   = rs_used;
        bus.id_rt        = rt;
        bus.id_rt_used   = rt_used;
        bus.id_dst       = dst;
        bus.id_reg_write = rw;
        bus.id_is_load   = ld;
        bus.flush        = fl;
        exp_q.push_back(exp_fwd);
    endtask

    task automatic idle(input int n);
        bus.id_valid     = 1'b0;
        bus.id_rs_used   = 1'b0;
        bus.id_rt_used   = 1'b0;
        bus.id_reg_write = 1'b0;
        bus.id_is_load   = 1'b0;
        bus.flush        = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.id_valid     = 1'b1;
        bus.id_rs        = 5'($urandom_range(1, 31));
        bus.id_rt        = 5'($urandom_range(1, 31));
        bus.id_rs_used   = 1'b1;
        bus.id_rt_used   = 1'b1;
        bus.id_dst       = 5'($urandom_range(1, 31));
        bus.id_reg_write = 1'b1;
        bus.id_is_load   = 1'b1;
        bus.flush        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bus.load_write_predicate !== 1'b0) begin
            $display("FAIL reset_pred: got %b expected 0", bus.load_write_predicate);
            n_fail++;
        end
        n_tests++;
        if ({bus.fwd_a_sel, bus.fwd_b_sel} !== 4'h0) begin
            $display("FAIL reset_fwd: got %h expected 0", {bus.fwd_a_sel, bus.fwd_b_sel});
            n_fail++;
        end
        n_tests++;
        if ({bus.dbg_ex.valid, bus.dbg_mem.valid, bus.dbg_wb.valid} !== 3'b000) begin
            $display("FAIL reset_sb: got %b expected 000",
                     {bus.dbg_ex.valid, bus.dbg_mem.valid, bus.dbg_wb.valid});
            n_fail++;
        end
        rst = 1'b0;
        idle(1);
    endtask

    // lw $8 ; add rs=8 (x3)
    task automatic test_load_use();
        logic [3:0]      ep;
        logic [3:0][3:0] ef;
        ep = FWD_EN ? 4'b0010 : 4'b0110;
        ef = FWD_EN ? {4'h0, 4'h8, 4'h0, 4'h0} : '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) apply(1, 5'd1, 1, 5'd2, 0, 5'd8, 1, 1, 0, ef[i]);
            else        apply(1, 5'd8, 1, 5'd2, 1, 5'd10, 1, 0, 0, ef[i]);
            @(negedge clk);
            n_tests++;
            if (bus.load_write_predicate !== ep[i]) begin
                $display("FAIL load_use_pred[%0d]: got %b expected %b", i, bus.load_write_predicate, ep[i]);
                n_fail++;
            end
            @(posedge clk); #1;
            n_tests++;
            if ({bus.fwd_a_sel, bus.fwd_b_sel} !== exp_q[0]) begin
                $display("FAIL load_use_fwd[%0d]: got %h expected %h", i, {bus.fwd_a_sel, bus.fwd_b_sel}, exp_q[0]);
                n_fail++;
            end
            void'(exp_q.pop_front());
        end
        idle(4);
    endtask

    // add $9 ; sub rt=9 (x3)
    task automatic test_fwd_exmem();
        logic [3:0]      ep;
        logic [3:0][3:0] ef;
        ep = FWD_EN ? 4'b0000 : 4'b0110;
        ef = FWD_EN ? {4'h0, 4'h2, 4'h1, 4'h0} : '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) apply(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 0, ef[i]);
            else        apply(1, 5'd3, 1, 5'd9, 1, 5'd11, 1, 0, 0, ef[i]);
            @(negedge clk);
            n_tests++;
            if (bus.load_write_predicate !== ep[i]) begin
                $display("FAIL exmem_pred[%0d]: got %b expected %b", i, bus.load_write_predicate, ep[i]);
                n_fail++;
            end
            @(posedge clk); #1;
            n_tests++;
            if ({bus.fwd_a_sel, bus.fwd_b_sel} !== exp_q[0]) begin
                $display("FAIL exmem_fwd[%0d]: got %h expected %h", i, {bus.fwd_a_sel, bus.fwd_b_sel}, exp_q[0]);
                n_fail++;
            end
            void'(exp_q.pop_front());
        end
        idle(4);
    endtask

    // add $5 ; add $5 ; or rs=5 (rt=5 but not read) (x3)
    task automatic test_youngest_wins();
        logic [4:0]      ep;
        logic [4:0][3:0] ef;
        ep = FWD_EN ? 5'b00000 : 5'b01100;
        ef = FWD_EN ? {4'h0, 4'h8, 4'h4, 4'h0, 4'h0} : '0;
        for (int i = 0; i < 5; i++) begin
            if (i < 2) apply(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, ef[i]);
            else       apply(1, 5'd5, 1, 5'd5, 0, 5'd12, 1, 0, 0, ef[i]);
            @(negedge clk);
            n_tests++;
            if (bus.load_write_predicate !== ep[i]) begin
                $display("FAIL youngest_pred[%0d]: got %b expected %b", i, bus.load_write_predicate, ep[i]);
                n_fail++;
            end
            @(posedge clk); #1;
            n_tests++;
            if ({bus.fwd_a_sel, bus.fwd_b_sel} !== exp_q[0]) begin
                $display("FAIL youngest_fwd[%0d]: got %h expected %h", i, {bus.fwd_a_sel, bus.fwd_b_sel}, exp_q[0]);
                n_fail++;
            end
            void'(exp_q.pop_front());
        end
        idle(4);
    endtask

    // lw $0 ; consumer of $0
    task automatic test_reg_zero();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) apply(1, 5'd1, 1, 5'd2, 0, 5'd0, 1, 1, 0, 4'h0);
            else        apply(1, 5'd0, 1, 5'd0, 1, 5'd13, 1, 0, 0, 4'h0);
            @(negedge clk);
            n_tests++;
            if (bus.load_write_predicate !== 1'b0) begin
                $display("FAIL reg0_pred[%0d]: got %b expected 0", i, bus.load_write_predicate);
                n_fail++;
            end
            @(posedge clk); #1;
            n_tests++;
            if ({bus.fwd_a_sel, bus.fwd_b_sel} !== exp_q[0]) begin
                $display("FAIL reg0_fwd[%0d]: got %h expected %h", i, {bus.fwd_a_sel, bus.fwd_b_sel}, exp_q[0]);
                n_fail++;
            end
            void'(exp_q.pop_front());
            if (i == 0) begin
                n_tests++;
                if (bus.dbg_ex.valid !== 1'b0) begin
                    $display("FAIL reg0_ex_valid: got %b expected 0", bus.dbg_ex.valid);
                    n_fail++;
                end
            end
        end
        idle(4);
    endtask

    // lw $3 ; consumer of $3 with flush ; consumer of $3 (x2)
    task automatic test_flush();
        logic [3:0]      ep;
        logic [3:0][3:0] ef;
        ep = FWD_EN ? 4'b0000 : 4'b0100;
        ef = FWD_EN ? {4'h0, 4'h8, 4'h0, 4'h0} : '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) apply(1, 5'd1, 1, 5'd2, 0, 5'd3, 1, 1, 0, ef[i]);
            else        apply(1, 5'd3, 1, 5'd4, 0, 5'd14, 1, 0, (i == 1), ef[i]);
            @(negedge clk);
            n_tests++;
            if (bus.load_write_predicate !== ep[i]) begin
                $display("FAIL flush_pred[%0d]: got %b expected %b", i, bus.load_write_predicate, ep[i]);
                n_fail++;
            end
            @(posedge clk); #1;
            n_tests++;
            if ({bus.fwd_a_sel, bus.fwd_b_sel} !== exp_q[0]) begin
                $display("FAIL flush_fwd[%0d]: got %h expected %h", i, {bus.fwd_a_sel, bus.fwd_b_sel}, exp_q[0]);
                n_fail++;
            end
            void'(exp_q.pop_front());
            if (i == 1) begin
                n_tests++;
                if (bus.dbg_ex.valid !== 1'b0) begin
                    $display("FAIL flush_ex_valid: got %b expected 0", bus.dbg_ex.valid);
                    n_fail++;
                end
            end
        end
        idle(4);
    endtask

    // lw $4 ; lw $6 ; consumer rs=4 rt=6 (x3)
    task automatic test_back_to_back();
        logic [4:0]      ep;
        logic [4:0][3:0] ef;
        ep = FWD_EN ? 5'b00100 : 5'b01100;
        ef = FWD_EN ? {4'h0, 4'h2, 4'h0, 4'h0, 4'h0} : '0;
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      apply(1, 5'd1, 1, 5'd2, 0, 5'd4, 1, 1, 0, ef[i]);
            else if (i == 1) apply(1, 5'd1, 1, 5'd2, 0, 5'd6, 1, 1, 0, ef[i]);
            else             apply(1, 5'd4, 1, 5'd6, 1, 5'd15, 1, 0, 0, ef[i]);
            @(negedge clk);
            n_tests++;
            if (bus.load_write_predicate !== ep[i]) begin
                $display("FAIL b2b_pred[%0d]: got %b expected %b", i, bus.load_write_predicate, ep[i]);
                n_fail++;
            end
            @(posedge clk); #1;
            n_tests++;
            if ({bus.fwd_a_sel, bus.fwd_b_sel} !== exp_q[0]) begin
                $display("FAIL b2b_fwd[%0d]: got %h expected %h", i, {bus.fwd_a_sel, bus.fwd_b_sel}, exp_q[0]);
                n_fail++;
            end
            void'(exp_q.pop_front());
        end
        idle(4);
    endtask

    // lw $7 ; consumer stalls ; rst asserted mid-stall ; consumer after release
    task automatic test_reset_mid_stall();
        apply(1, 5'd1, 1, 5'd2, 0, 5'd7, 1, 1, 0, 4'h0);
        @(posedge clk); #1;
        void'(exp_q.pop_front());
        apply(1, 5'd7, 1, 5'd2, 0, 5'd16, 1, 0, 0, 4'h0);
        @(negedge clk);
        n_tests++;
        if (bus.load_write_predicate !== 1'b1) begin
            $display("FAIL rst_stall_pre: got %b expected 1", bus.load_write_predicate);
            n_fail++;
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.load_write_predicate !== 1'b0) begin
            $display("FAIL rst_stall_drop: got %b expected 0", bus.load_write_predicate);
            n_fail++;
        end
        @(posedge clk); #1;
        n_tests++;
        if ({bus.fwd_a_sel, bus.fwd_b_sel} !== exp_q[0]) begin
            $display("FAIL rst_stall_fwd: got %h expected %h", {bus.fwd_a_sel, bus.fwd_b_sel}, exp_q[0]);
            n_fail++;
        end
        void'(exp_q.pop_front());
        n_tests++;
        if ({bus.dbg_ex.valid, bus.dbg_mem.valid, bus.dbg_wb.valid} !== 3'b000) begin
            $display("FAIL rst_stall_sb: got %b expected 000",
                     {bus.dbg_ex.valid, bus.dbg_mem.valid, bus.dbg_wb.valid});
            n_fail++;
        end
        rst = 1'b0;
        apply(1, 5'd7, 1, 5'd2, 0, 5'd16, 1, 0, 0, 4'h0);
        @(negedge clk);
        n_tests++;
        if (bus.load_write_predicate !== 1'b0) begin
            $display("FAIL rst_after_pred: got %b expected 0", bus.load_write_predicate);
            n_fail++;
        end
        @(posedge clk); #1;
        n_tests++;
        if ({bus.fwd_a_sel, bus.fwd_b_sel} !== exp_q[0]) begin
            $display("FAIL rst_after_fwd: got %h expected %h", {bus.fwd_a_sel, bus.fwd_b_sel}, exp_q[0]);
            n_fail++;
        end
        void'(exp_q.pop_front());
        idle(4);
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_load_use();
        test_fwd_exmem();
        test_youngest_wins();
        test_reg_zero();
        test_flush();
        test_back_to_back();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
